// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word fall-through output; otherwise data_out is registered.
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int ADR_WIDTH = 3,
  parameter int DEPTH     = 2**ADR_WIDTH,
  parameter int AF_LEVEL  = DEPTH-2,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     data_out,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [ADR_WIDTH:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 err_clr
);

  localparam int CNT_W = ADR_WIDTH + 1;
  localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]     AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]     AE_CNT   = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [ADR_WIDTH-1:0] PTR_ONE  = ADR_WIDTH'(1);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADR_WIDTH-1:0] wr_ptr;
  logic [ADR_WIDTH-1:0] rd_ptr;
  logic                 wr_acc;
  logic                 rd_acc;

  // Occupancy moves only when exactly one side is accepted.
  function automatic logic [CNT_W-1:0] next_count(
    input logic [CNT_W-1:0] cur,
    input logic             wr,
    input logic             rd
  );
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (wr && !rd)
      nxt = cur + CNT_ONE;
    else if (rd && !wr)
      nxt = cur - CNT_ONE;
    return nxt;
  endfunction

  always_comb begin
    empty        = (count == '0);
    full         = (count == FULL_CNT);
    almost_empty = (count <= AE_CNT);
    almost_full  = (count >= AF_CNT);
    wr_acc       = wr_en && !full;
    rd_acc       = rd_en && !empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc)
        rd_ptr <= rd_ptr + PTR_ONE;
      count <= next_count(count, wr_acc, rd_acc);
    end
  end

  // A fresh error in the same cycle takes priority over err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)
        overflow <= 1'b1;
      else if (err_clr)
        overflow <= 1'b0;
      if (rd_en && empty)
        underflow <= 1'b1;
      else if (err_clr)
        underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  always_comb begin
    data_out = '0;
    if (!empty)
      data_out = mem[rd_ptr];
  end
`else
  always_ff @(posedge clk) begin
    if (rst)
      data_out <= '0;
    else if (rd_acc)
      data_out <= mem[rd_ptr];
  end
`endif

endmodule
